// File: rtl/rotor_decoder.sv
// rtl/rotor_decoder.sv - rotary encoder synchronizer, debouncer, quadrature decoder and event register
module rotor_decoder #(
    parameter int DEBOUNCE  = 2,
    parameter int POS_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ROT_A,
    input  logic                 ROT_B,
    input  logic                 ROT_CENTER,
    input  logic                 EVT_ACK,
    output logic                 EVT_VALID,
    output logic [1:0]           EVT_CODE,
    output logic [POS_WIDTH-1:0] POSITION,
    output logic                 OVERFLOW
);

    localparam int              CW       = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0]   DB_MAX   = CW'(DEBOUNCE);
    // Line order is {CENTER, B, A}; idle encoder rests at A=1, B=1, released.
    localparam logic [2:0]      LINE_RST = 3'b011;

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_LEFT  = 2'b01;
    localparam logic [1:0] CODE_RIGHT = 2'b10;
    localparam logic [1:0] CODE_PRESS = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_L1,
        S_R1,
        S_L2,
        S_R2,
        S_WAIT
    } state_t;

    logic [2:0]    raw;
    logic [2:0]    sync1_q, sync2_q, filt_q;
    logic [CW-1:0] cnt_q [3];
    logic [1:0]    ab;
    state_t        state_q;
    logic [POS_WIDTH-1:0] pos_q;
    logic          center_prev_q;
    logic          pend_q, pend_d;
    logic          ovf_q, ovf_set;
    logic          evt_valid_q;
    logic [1:0]    evt_code_q, code_d;
    logic          offer, slot_free, turn_l, turn_r, press_rise;

    assign raw = {ROT_CENTER, ROT_B, ROT_A};
    assign ab  = {filt_q[0], filt_q[1]};

    // Two-flop synchronizer followed by a per-line hold counter; filtered level follows only after DEBOUNCE disagreeing cycles.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q <= LINE_RST;
            sync2_q <= LINE_RST;
            filt_q  <= LINE_RST;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] != filt_q[i]) begin
                    if (cnt_q[i] == DB_MAX) begin
                        filt_q[i] <= sync2_q[i];
                        cnt_q[i]  <= '0;
                    end else begin
                        cnt_q[i]  <= cnt_q[i] + CW'(1);
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    // A turn completes when a committed direction returns to the detent (11).
    assign turn_l     = (state_q == S_L2) && (ab == 2'b11);
    assign turn_r     = (state_q == S_R2) && (ab == 2'b11);
    assign press_rise = filt_q[2] & ~center_prev_q;

    // Quadrature FSM and position counter; position moves even when the event itself is dropped.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= S_IDLE;
            pos_q         <= '0;
            center_prev_q <= 1'b0;
        end else begin
            center_prev_q <= filt_q[2];
            if (turn_l) pos_q <= pos_q - POS_WIDTH'(1);
            if (turn_r) pos_q <= pos_q + POS_WIDTH'(1);
            case (state_q)
                S_IDLE: case (ab)
                    2'b01:   state_q <= S_L1;
                    2'b10:   state_q <= S_R1;
                    2'b00:   state_q <= S_WAIT;
                    default: state_q <= S_IDLE;
                endcase
                S_L1: case (ab)
                    2'b00:   state_q <= S_L2;
                    2'b11:   state_q <= S_IDLE;
                    2'b10:   state_q <= S_WAIT;
                    default: state_q <= S_L1;
                endcase
                S_R1: case (ab)
                    2'b00:   state_q <= S_R2;
                    2'b11:   state_q <= S_IDLE;
                    2'b01:   state_q <= S_WAIT;
                    default: state_q <= S_R1;
                endcase
                S_L2, S_R2, S_WAIT: if (ab == 2'b11) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign slot_free = !evt_valid_q || EVT_ACK;

    // Arbitration: a turn wins the cycle and parks a coincident press in the one-deep pending flag.
    always_comb begin
        offer   = 1'b0;
        code_d  = CODE_NONE;
        pend_d  = pend_q;
        ovf_set = 1'b0;
        if (turn_l || turn_r) begin
            offer  = 1'b1;
            code_d = turn_l ? CODE_LEFT : CODE_RIGHT;
            if (press_rise) begin
                if (pend_q) ovf_set = 1'b1;
                else        pend_d  = 1'b1;
            end
        end else if (pend_q) begin
            offer  = 1'b1;
            code_d = CODE_PRESS;
            pend_d = 1'b0;
            if (press_rise) ovf_set = 1'b1;
        end else if (press_rise) begin
            offer  = 1'b1;
            code_d = CODE_PRESS;
        end
        if (offer && !slot_free) ovf_set = 1'b1;
    end

    // One-deep event register with valid/ack handshake and sticky overflow.
    always_ff @(posedge CLK) begin
        if (RST) begin
            evt_valid_q <= 1'b0;
            evt_code_q  <= CODE_NONE;
            pend_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            pend_q <= pend_d;
            if (ovf_set) ovf_q <= 1'b1;
            if (offer && slot_free) begin
                evt_valid_q <= 1'b1;
                evt_code_q  <= code_d;
            end else if (evt_valid_q && EVT_ACK) begin
                evt_valid_q <= 1'b0;
                evt_code_q  <= CODE_NONE;
            end
        end
    end

    assign EVT_VALID = evt_valid_q;
    assign EVT_CODE  = evt_code_q;
    assign POSITION  = pos_q;
    assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_rotor_decoder.sv
// tb/tb_rotor_decoder.sv - directed self-checking bench for rotor_decoder
module tb_rotor_decoder;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       ROT_A = 1'b1;
    logic       ROT_B = 1'b1;
    logic       ROT_CENTER = 1'b0;
    logic       EVT_ACK = 1'b0;
    logic       EVT_VALID;
    logic [1:0] EVT_CODE;
    logic [7:0] POSITION;
    logic       OVERFLOW;

    int checks = 0;
    int failures = 0;
    int cons_cnt = 0;
    logic [1:0] codes [$];

    rotor_decoder #(.DEBOUNCE(2), .POS_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .ROT_A      (ROT_A),
        .ROT_B      (ROT_B),
        .ROT_CENTER (ROT_CENTER),
        .EVT_ACK    (EVT_ACK),
        .EVT_VALID  (EVT_VALID),
        .EVT_CODE   (EVT_CODE),
        .POSITION   (POSITION),
        .OVERFLOW   (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    // Record every event the consumer takes (valid and ack both high ahead of a rising edge).
    always @(negedge CLK) begin
        if (!RST && EVT_VALID && EVT_ACK) begin
            cons_cnt++;
            codes.push_back(EVT_CODE);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        RST = 1'b1; ROT_A = 1'b1; ROT_B = 1'b1; ROT_CENTER = 1'b0; EVT_ACK = 1'b0;
        wait_cyc(3);
        RST = 1'b0;
        cons_cnt = 0;
        codes.delete();
        wait_cyc(2);
    endtask

    task automatic turn_left();
        ROT_A = 1'b0; wait_cyc(25);
        ROT_B = 1'b0; wait_cyc(30);
        ROT_A = 1'b1; wait_cyc(5);
        ROT_B = 1'b1; wait_cyc(50);
    endtask

    task automatic turn_right();
        ROT_B = 1'b0; wait_cyc(25);
        ROT_A = 1'b0; wait_cyc(30);
        ROT_B = 1'b1; wait_cyc(5);
        ROT_A = 1'b1; wait_cyc(50);
    endtask

    task automatic press();
        ROT_CENTER = 1'b1; wait_cyc(20);
        ROT_CENTER = 1'b0; wait_cyc(20);
    endtask

    task automatic ack_pulse();
        EVT_ACK = 1'b1; wait_cyc(1);
        EVT_ACK = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (EVT_VALID !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b expected 0", EVT_VALID); end
        checks++; if (EVT_CODE !== 2'b00) begin failures++; $display("FAIL reset_code: got %0b expected 00", EVT_CODE); end
        checks++; if (POSITION !== 8'h00) begin failures++; $display("FAIL reset_pos: got %0h expected 00", POSITION); end
        checks++; if (OVERFLOW !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %0b expected 0", OVERFLOW); end
    endtask

    task automatic test_turn_left();
        do_reset();
        EVT_ACK = 1'b1;
        turn_left();
        EVT_ACK = 1'b0;
        checks++; if (cons_cnt !== 1) begin failures++; $display("FAIL left_count: got %0d expected 1", cons_cnt); end
        checks++; if (codes.size() < 1 || codes[0] !== 2'b01) begin failures++; $display("FAIL left_code: got %0b expected 01", (codes.size() > 0) ? codes[0] : 2'bxx); end
        checks++; if (POSITION !== 8'hFF) begin failures++; $display("FAIL left_pos: got %0h expected ff", POSITION); end
        checks++; if (OVERFLOW !== 1'b0) begin failures++; $display("FAIL left_ovf: got %0b expected 0", OVERFLOW); end
    endtask

    task automatic test_turn_right();
        logic [7:0] exp_pos;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            exp_pos = 8'(i);
            turn_right();
            checks++; if (EVT_VALID !== 1'b1) begin failures++; $display("FAIL right%0d_valid: got %0b expected 1", i, EVT_VALID); end
            checks++; if (EVT_CODE !== 2'b10) begin failures++; $display("FAIL right%0d_code: got %0b expected 10", i, EVT_CODE); end
            checks++; if (POSITION !== exp_pos) begin failures++; $display("FAIL right%0d_pos: got %0h expected %0h", i, POSITION, exp_pos); end
            ack_pulse();
            checks++; if (EVT_VALID !== 1'b0) begin failures++; $display("FAIL right%0d_ack_valid: got %0b expected 0", i, EVT_VALID); end
            checks++; if (EVT_CODE !== 2'b00) begin failures++; $display("FAIL right%0d_ack_code: got %0b expected 00", i, EVT_CODE); end
        end
        checks++; if (OVERFLOW !== 1'b0) begin failures++; $display("FAIL right_ovf: got %0b expected 0", OVERFLOW); end
    endtask

    task automatic test_press_overflow();
        do_reset();
        press();
        checks++; if (EVT_VALID !== 1'b1) begin failures++; $display("FAIL press_valid: got %0b expected 1", EVT_VALID); end
        checks++; if (EVT_CODE !== 2'b11) begin failures++; $display("FAIL press_code: got %0b expected 11", EVT_CODE); end
        checks++; if (OVERFLOW !== 1'b0) begin failures++; $display("FAIL press_ovf_early: got %0b expected 0", OVERFLOW); end
        press();
        checks++; if (OVERFLOW !== 1'b1) begin failures++; $display("FAIL press_ovf: got %0b expected 1", OVERFLOW); end
        checks++; if (EVT_CODE !== 2'b11 || EVT_VALID !== 1'b1) begin failures++; $display("FAIL press_held: got valid=%0b code=%0b expected valid=1 code=11", EVT_VALID, EVT_CODE); end
        ack_pulse();
        checks++; if (EVT_VALID !== 1'b0) begin failures++; $display("FAIL press_ack: got %0b expected 0", EVT_VALID); end
        wait_cyc(20);
        checks++; if (EVT_VALID !== 1'b0) begin failures++; $display("FAIL press_after: got %0b expected 0", EVT_VALID); end
        checks++; if (OVERFLOW !== 1'b1) begin failures++; $display("FAIL press_ovf_sticky: got %0b expected 1", OVERFLOW); end
    endtask

    task automatic test_abort_glitch();
        do_reset();
        EVT_ACK = 1'b1;
        ROT_A = 1'b0; wait_cyc(15);
        ROT_A = 1'b1; wait_cyc(20);
        checks++; if (cons_cnt !== 0) begin failures++; $display("FAIL abort_count: got %0d expected 0", cons_cnt); end
        checks++; if (POSITION !== 8'h00) begin failures++; $display("FAIL abort_pos: got %0h expected 00", POSITION); end
        ROT_B = 1'b0; wait_cyc(1);
        ROT_B = 1'b1; wait_cyc(20);
        checks++; if (cons_cnt !== 0) begin failures++; $display("FAIL glitch_count: got %0d expected 0", cons_cnt); end
        turn_right();
        EVT_ACK = 1'b0;
        checks++; if (cons_cnt !== 1 || codes.size() < 1 || codes[0] !== 2'b10) begin failures++; $display("FAIL glitch_turn: got count=%0d expected 1 event code 10", cons_cnt); end
        checks++; if (POSITION !== 8'h01) begin failures++; $display("FAIL glitch_pos: got %0h expected 01", POSITION); end
    endtask

    task automatic test_reset_mid_turn();
        do_reset();
        EVT_ACK = 1'b1;
        ROT_A = 1'b0; wait_cyc(25);
        ROT_B = 1'b0; wait_cyc(30);
        RST = 1'b1; wait_cyc(2);
        RST = 1'b0; wait_cyc(10);
        ROT_A = 1'b1; wait_cyc(5);
        ROT_B = 1'b1; wait_cyc(50);
        checks++; if (cons_cnt !== 0) begin failures++; $display("FAIL midrst_count: got %0d expected 0", cons_cnt); end
        checks++; if (POSITION !== 8'h00) begin failures++; $display("FAIL midrst_pos: got %0h expected 00", POSITION); end
        turn_right();
        EVT_ACK = 1'b0;
        checks++; if (cons_cnt !== 1 || codes.size() < 1 || codes[0] !== 2'b10) begin failures++; $display("FAIL midrst_turn: got count=%0d expected 1 event code 10", cons_cnt); end
        checks++; if (POSITION !== 8'h01) begin failures++; $display("FAIL midrst_pos2: got %0h expected 01", POSITION); end
    endtask

    task automatic test_turn_and_press();
        do_reset();
        EVT_ACK = 1'b1;
        ROT_A = 1'b0; wait_cyc(25);
        ROT_B = 1'b0; wait_cyc(30);
        ROT_A = 1'b1; wait_cyc(5);
        ROT_B = 1'b1; ROT_CENTER = 1'b1; wait_cyc(50);
        ROT_CENTER = 1'b0; wait_cyc(20);
        EVT_ACK = 1'b0;
        checks++; if (cons_cnt !== 2) begin failures++; $display("FAIL simul_count: got %0d expected 2", cons_cnt); end
        checks++; if (codes.size() < 2 || codes[0] !== 2'b01 || codes[1] !== 2'b11) begin failures++; $display("FAIL simul_order: got size=%0d expected codes 01 then 11", codes.size()); end
        checks++; if (OVERFLOW !== 1'b0) begin failures++; $display("FAIL simul_ovf: got %0b expected 0", OVERFLOW); end
        checks++; if (POSITION !== 8'hFF) begin failures++; $display("FAIL simul_pos: got %0h expected ff", POSITION); end
    endtask

    initial begin
        @(posedge CLK);
        #1;
        test_reset();
        test_turn_left();
        test_turn_right();
        test_press_overflow();
        test_abort_glitch();
        test_reset_mid_turn();
        test_turn_and_press();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
